blink_sequencer: RTL and testbench
==================================

// Module: blink_sequencer
// PURPOSE
//   Chase sequencer that schedules NCH blink channels off the shared 16-bit free-running counter.
//   Holds per-channel mask/offset config, loaded through a byte-wide write port.
//   Steps the active channel on each rising edge of a chosen counter bit.
//   Drives registered LED outputs; sits between the shared counter and uo_out in tt_um_mrmola.
// PARAMETERS
//   NCH      4    number of blink channels (1..4; addr field is fixed 2 bits)
//   CW       16   counter width
//   STEP_BIT 12   counter bit whose 0->1 transition is one step tick
// PORTS
//   clk        in   1      system clock; the only clock in the block
//   rst        in   1      asynchronous reset, active-high; clears all state
//   ena        in   1      0 = freeze: FSM, step_idx and loop count hold; led_out forced 0
//   count_in   in   CW     shared free-running counter value
//   start      in   1      pulse; in IDLE starts a sequence
//   stop       in   1      pulse; aborts to IDLE from any state
//   cfg_we     in   1      config write strobe
//   cfg_addr   in   5      [4]=0: channel reg, [3:2]=ch, [1:0]=byte; 5'h10 = LOOPS
//   cfg_data   in   8      write data
//   led_out    out  NCH    registered per-channel blink outputs
//   step_idx   out  2      currently active channel
//   busy       out  1      1 while FSM in RUN
//   done       out  1      one-cycle pulse when the loop budget is exhausted
// BEHAVIOUR
//   Reset values: led_out=0, step_idx=0, busy=0, done=0, FSM=IDLE, tick history=0.
//   Register reset: every MASK_c=16'h0064, OFF_c=0, LOOPS=0.
//   Config bytes: 0=MASK lo, 1=MASK hi, 2=OFF lo, 3=OFF hi.
//   Writes to ch>=NCH or to undefined addresses are ignored.
//   Writes are accepted in every state and when ena=0; new value is used from the next cycle.
//   Blink term: blink_c = (((count_in + OFF_c) mod 2^CW) & MASK_c) != 0; the add wraps, no carry out.
//   Step tick: tick = count_in[STEP_BIT] & ~prev_bit.
//     prev_bit is registered every cycle, including while ena=0.
//   FSM IDLE:
//     start & ~stop -> RUN; step_idx<=0; loop_cnt<=LOOPS, latched at start.
//     LOOPS writes made during RUN do not affect the current run.
//     A tick in the start cycle is ignored.
//   FSM RUN, on tick:
//     step_idx<NCH-1 -> step_idx+1.
//     step_idx==NCH-1 -> step_idx<=0 and one pass completes:
//       if loop_cnt==1 -> DONE;
//       else if loop_cnt!=0, loop_cnt-1;
//       LOOPS=0 means run forever.
//   FSM DONE: lasts one cycle; done=1 in it; then IDLE with step_idx=0.
//   stop in any state -> IDLE next cycle; stop beats start and tick in the same cycle; no done pulse.
//   start while in RUN or DONE is ignored.
//   led_out[c] <= (FSM==RUN && ena && c==step_idx) ? blink_c : 0.
//     One clk of latency from count_in, registered.
//     At most one bit is set at a time.
//   busy is the registered decode of FSM==RUN.
//   ena=0: FSM, step_idx and loop_cnt hold; ticks are dropped and not queued; led_out=0 next cycle.
// TESTING
//   1 Reset: assert rst mid-RUN, async -> led_out, busy, step_idx all 0 before the next clk edge;
//     reads back MASK=0x0064.
//   2 Blink term: ch0 MASK=0x0100, OFF=0, start -> led_out[0] follows count_in[8], one cycle late;
//     OFF=0x0080 shifts the phase by 128 counts.
//   3 Chase: NCH=4, LOOPS=2, STEP_BIT=4, count from 0 -> step_idx 0,1,2,3,0,1,2,3;
//     done pulses on the 8th tick; then IDLE, busy=0.
//   4 Wrap: OFF=0xFFFF, count_in=0x0001, MASK=0x0001 -> sum 0x0000, led 0;
//     at count_in=0x0002 -> sum 0x0001, led 1.
//   5 Conflicts: start+stop same cycle -> stays IDLE; stop together with final tick -> no done;
//     LOOPS write mid-run -> run length unchanged.
//   6 ena=0 for 3 ticks in RUN -> step_idx frozen, led_out=0;
//     ena back to 1 -> resumes from the same step.

Source files
------------

// File: rtl/blink_sequencer.sv
// Chase sequencer: steps one active blink channel per rising edge of a counter bit,
// each channel blinking from its own mask/offset view of the shared free-running counter.
module blink_sequencer #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CW       = 16,
    parameter int unsigned STEP_BIT = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [CW-1:0]  count_in,
    input  logic           start,
    input  logic           stop,
    input  logic           cfg_we,
    input  logic [4:0]     cfg_addr,
    input  logic [7:0]     cfg_data,
    output logic [NCH-1:0] led_out,
    output logic [1:0]     step_idx,
    output logic           busy,
    output logic           done
);

    localparam int unsigned SW = 2;
    localparam int unsigned LW = 8;
    localparam logic [SW-1:0] LAST_CH   = SW'(NCH - 1);
    localparam logic [4:0]    LOOPS_ADR = 5'h10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SW-1:0]   r_step_idx;
    logic [SW-1:0]   w_step_next;
    logic [LW-1:0]   r_loop_cnt;
    logic [LW-1:0]   w_loop_next;
    logic [LW-1:0]   r_loops;
    logic            r_prev_bit;
    logic            w_tick;
    logic [CW-1:0]   r_mask [NCH];
    logic [CW-1:0]   r_off  [NCH];
    logic [CW-1:0]   w_sum  [NCH];
    logic [NCH-1:0]  w_blink;
    logic [NCH-1:0]  w_led_next;
    logic [NCH-1:0]  r_led;
    logic            r_busy;
    logic            r_done;

    assign led_out  = r_led;
    assign step_idx = r_step_idx;
    assign busy     = r_busy;
    assign done     = r_done;

    assign w_tick = count_in[STEP_BIT] & ~r_prev_bit;

    // Byte-wide config port; writes land regardless of FSM state or ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_mask[c] <= CW'(16'h0064);
                r_off[c]  <= '0;
            end
            r_loops <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == LOOPS_ADR) begin
                r_loops <= cfg_data;
            end else if (!cfg_addr[4]) begin
                for (int c = 0; c < NCH; c++) begin
                    if (cfg_addr[3:2] == SW'(c)) begin
                        case (cfg_addr[1:0])
                            2'd0:    r_mask[c][7:0]  <= cfg_data;
                            2'd1:    r_mask[c][15:8] <= cfg_data;
                            2'd2:    r_off[c][7:0]   <= cfg_data;
                            default: r_off[c][15:8]  <= cfg_data;
                        endcase
                    end
                end
            end
        end
    end

    // Per-channel blink term; the offset add wraps at CW bits.
    always_comb begin
        w_blink    = '0;
        w_led_next = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sum[c]      = count_in + r_off[c];
            w_blink[c]    = |(w_sum[c] & r_mask[c]);
            w_led_next[c] = (r_state == S_RUN) && ena && (r_step_idx == SW'(c)) && w_blink[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step_idx <= '0;
            r_loop_cnt <= '0;
            r_prev_bit <= 1'b0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_step_idx <= w_step_next;
            r_loop_cnt <= w_loop_next;
            r_prev_bit <= count_in[STEP_BIT];
            r_led      <= w_led_next;
            r_busy     <= (w_state_next == S_RUN);
            r_done     <= (w_state_next == S_DONE);
        end
    end

    // ena=0 freezes the sequencer completely, so ticks seen while frozen are lost.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step_idx;
        w_loop_next  = r_loop_cnt;
        if (ena) begin
            if (stop) begin
                w_state_next = S_IDLE;
                w_step_next  = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            w_state_next = S_RUN;
                            w_step_next  = '0;
                            w_loop_next  = r_loops;
                        end
                    end
                    S_RUN: begin
                        if (w_tick) begin
                            if (r_step_idx == LAST_CH) begin
                                w_step_next = '0;
                                if (r_loop_cnt == LW'(1)) begin
                                    w_state_next = S_DONE;
                                end else if (r_loop_cnt != '0) begin
                                    w_loop_next = r_loop_cnt - LW'(1);
                                end
                            end else begin
                                w_step_next = r_step_idx + SW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        w_state_next = S_IDLE;
                        w_step_next  = '0;
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_step_next  = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer; step tick taken from counter bit 4 to keep runs short.
module tb_blink_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] count_in;
    logic        start;
    logic        stop;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [3:0]  led_out;
    logic [1:0]  step_idx;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    blink_sequencer #(.NCH(4), .CW(16), .STEP_BIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .count_in (count_in),
        .start    (start),
        .stop     (stop),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .led_out  (led_out),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (led_out !== 4'b0000) $display("FAIL rst_led got=%b exp=0000", led_out); else n_pass++;
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); else n_pass++;
        n_total++; if (step_idx !== 2'd0) $display("FAIL rst_step got=%0d exp=0", step_idx); else n_pass++;
        rst = 1'b0;
        cyc(1);
        // default mask 0x0064 seen through channel 0
        count_in = 16'h0004;
        pulse_start;
        cyc(1);
        n_total++; if (led_out !== 4'b0001) $display("FAIL dflt_mask_hit got=%b exp=0001", led_out); else n_pass++;
        count_in = 16'h0001;
        cyc(1);
        n_total++; if (led_out !== 4'b0000) $display("FAIL dflt_mask_miss got=%b exp=0000", led_out); else n_pass++;
        count_in = 16'h0014;
        cyc(1);
        n_total++; if (step_idx !== 2'd1 || busy !== 1'b1) $display("FAIL pre_rst_step got=%0d/%b exp=1/1", step_idx, busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (led_out !== 4'b0000 || busy !== 1'b0 || step_idx !== 2'd0)
            $display("FAIL async_rst got led=%b busy=%b step=%0d exp=0000/0/0", led_out, busy, step_idx);
        else n_pass++;
        #2;
        rst = 1'b0;
        count_in = 16'h0000;
        cyc(1);
    endtask

    task automatic test_blink;
        wr(5'h00, 8'h00);
        wr(5'h01, 8'h01);
        count_in = 16'h0000;
        pulse_start;
        count_in = 16'h0100;
        n_total++; if (led_out !== 4'b0000) $display("FAIL blink_latency got=%b exp=0000", led_out); else n_pass++;
        cyc(1);
        n_total++; if (led_out !== 4'b0001) $display("FAIL blink_bit8_hi got=%b exp=0001", led_out); else n_pass++;
        count_in = 16'h0000;
        cyc(1);
        n_total++; if (led_out !== 4'b0000) $display("FAIL blink_bit8_lo got=%b exp=0000", led_out); else n_pass++;
        wr(5'h02, 8'h80);
        count_in = 16'h0080;
        cyc(1);
        n_total++; if (led_out !== 4'b0001) $display("FAIL blink_off_hi got=%b exp=0001", led_out); else n_pass++;
        count_in = 16'h0180;
        cyc(1);
        n_total++; if (led_out !== 4'b0000) $display("FAIL blink_off_lo got=%b exp=0000", led_out); else n_pass++;
        count_in = 16'h0000;
        pulse_stop;
    endtask

    task automatic test_wrap;
        wr(5'h00, 8'h01);
        wr(5'h01, 8'h00);
        wr(5'h02, 8'hFF);
        wr(5'h03, 8'hFF);
        count_in = 16'h0000;
        pulse_start;
        count_in = 16'h0001;
        cyc(1);
        n_total++; if (led_out !== 4'b0000) $display("FAIL wrap_zero got=%b exp=0000", led_out); else n_pass++;
        count_in = 16'h0002;
        cyc(1);
        n_total++; if (led_out !== 4'b0001) $display("FAIL wrap_one got=%b exp=0001", led_out); else n_pass++;
        count_in = 16'h0000;
        pulse_stop;
    endtask

    task automatic test_chase;
        wr(5'h10, 8'd2);
        count_in = 16'h0000;
        cyc(1);
        count_in = 16'h0010;
        pulse_start;
        n_total++; if (step_idx !== 2'd0 || busy !== 1'b1) $display("FAIL chase_start got=%0d/%b exp=0/1", step_idx, busy); else n_pass++;
        count_in = 16'h0000;
        cyc(1);
        for (int k = 1; k <= 8; k++) begin
            count_in = 16'h0010;
            cyc(1);
            if (k < 8) begin
                n_total++;
                if (step_idx !== 2'(k % 4) || done !== 1'b0 || busy !== 1'b1)
                    $display("FAIL chase_tick%0d got step=%0d done=%b busy=%b exp=%0d/0/1", k, step_idx, done, busy, k % 4);
                else n_pass++;
            end else begin
                n_total++;
                if (done !== 1'b1 || busy !== 1'b0 || step_idx !== 2'd0)
                    $display("FAIL chase_done got done=%b busy=%b step=%0d exp=1/0/0", done, busy, step_idx);
                else n_pass++;
            end
            count_in = 16'h0000;
            cyc(1);
        end
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL chase_idle got done=%b busy=%b exp=0/0", done, busy); else n_pass++;
    endtask

    task automatic test_conflicts;
        count_in = 16'h0000;
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL start_stop got busy=%b exp=0", busy); else n_pass++;
        cyc(1);
        n_total++; if (busy !== 1'b0) $display("FAIL start_stop_hold got busy=%b exp=0", busy); else n_pass++;
        // stop coinciding with the final tick
        wr(5'h10, 8'd1);
        pulse_start;
        for (int k = 1; k <= 3; k++) begin
            count_in = 16'h0010; cyc(1);
            count_in = 16'h0000; cyc(1);
        end
        count_in = 16'h0010;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL stop_final got done=%b busy=%b exp=0/0", done, busy); else n_pass++;
        count_in = 16'h0000;
        cyc(1);
        n_total++; if (done !== 1'b0) $display("FAIL stop_final_next got done=%b exp=0", done); else n_pass++;
        // LOOPS rewritten mid-run does not stretch the run
        pulse_start;
        wr(5'h10, 8'd3);
        for (int k = 1; k <= 4; k++) begin
            count_in = 16'h0010;
            cyc(1);
            n_total++;
            if (done !== (k == 4)) $display("FAIL loops_midrun_t%0d got done=%b exp=%b", k, done, (k == 4));
            else n_pass++;
            count_in = 16'h0000;
            cyc(1);
        end
    endtask

    task automatic test_ena;
        wr(5'h10, 8'd0);
        count_in = 16'h0004;
        pulse_start;
        count_in = 16'h0014; cyc(1);
        count_in = 16'h0004; cyc(1);
        n_total++; if (step_idx !== 2'd1 || led_out !== 4'b0010)
            $display("FAIL ena_pre got step=%0d led=%b exp=1/0010", step_idx, led_out);
        else n_pass++;
        ena = 1'b0;
        cyc(1);
        n_total++; if (led_out !== 4'b0000) $display("FAIL ena_off_led got=%b exp=0000", led_out); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            count_in = 16'h0014;
            cyc(1);
            n_total++;
            if (step_idx !== 2'd1 || led_out !== 4'b0000)
                $display("FAIL ena_frozen_t%0d got step=%0d led=%b exp=1/0000", k, step_idx, led_out);
            else n_pass++;
            count_in = 16'h0004;
            cyc(1);
        end
        ena = 1'b1;
        cyc(1);
        n_total++; if (step_idx !== 2'd1 || led_out !== 4'b0010 || busy !== 1'b1)
            $display("FAIL ena_resume got step=%0d led=%b busy=%b exp=1/0010/1", step_idx, led_out, busy);
        else n_pass++;
        count_in = 16'h0014;
        cyc(1);
        n_total++; if (step_idx !== 2'd2) $display("FAIL ena_resume_step got=%0d exp=2", step_idx); else n_pass++;
        count_in = 16'h0000;
        pulse_stop;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; count_in = 16'h0000;
        start = 1'b0; stop = 1'b0;
        cfg_we = 1'b0; cfg_addr = 5'h00; cfg_data = 8'h00;
        test_reset;
        test_blink;
        test_wrap;
        test_chase;
        test_conflicts;
        test_ena;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
